writeback_grf: RTL and testbench

WRITEBACK_GRF -- requirements
Module: writeback_grf

---
 rtl/writeback_grf_pkg.sv | 42 ++++
 rtl/writeback_grf_load_extend.sv | 29 ++
 rtl/writeback_grf.sv | 96 +++++++++
 tb/tb_writeback_grf.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/writeback_grf_pkg.sv
// Shared MIPS opcode/funct definitions used by the pipeline stages, plus
// the decode helpers the write-back stage needs.
package writeback_grf_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_LINK = 2'd2
  } wb_src_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_SLTIU) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_LUI);
  endfunction

endpackage

// File: rtl/writeback_grf_load_extend.sv
// Selects and extends the loaded byte/halfword/word from an aligned memory word.
module load_extend
  import writeback_grf_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] mem_data,
  input  logic [1:0]  off,
  output logic [31:0] data
);

  logic [31:0] byte_lane;
  logic [15:0] half_lane;

  // Halfword loads ignore off[0]; only off[1] picks the lane.
  assign byte_lane = mem_data >> {off, 3'b000};
  assign half_lane = off[1] ? mem_data[31:16] : mem_data[15:0];

  always_comb begin
    data = mem_data;
    case (op)
      OP_LB:   data = {{24{byte_lane[7]}}, byte_lane[7:0]};
      OP_LBU:  data = {24'h0, byte_lane[7:0]};
      OP_LH:   data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  data = {16'h0, half_lane};
      default: data = mem_data;
    endcase
  end

endmodule

// File: rtl/writeback_grf.sv
// Write-back stage: decodes the destination, selects write data, and owns
// the 32x32 register file with a same-cycle write-to-read bypass.
module writeback_grf
  import writeback_grf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_w,
  input  logic [31:0] instr_w,
  input  logic [31:0] mem_data_w,
  input  logic [31:0] alu_result_w,
  input  logic        we_w,
  input  logic [4:0]  rs_addr_d,
  input  logic [4:0]  rt_addr_d,
  output logic [31:0] rs_data_d,
  output logic [31:0] rt_data_d,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        dest_valid;
  logic [4:0]  dest;
  wb_src_e     src;
  logic [31:0] load_data;
  logic [31:0] write_data;
  logic [31:0] regs [0:31];
  logic        unused_fields;

  assign opcode = instr_w[31:26];
  assign rt     = instr_w[20:16];
  assign rd     = instr_w[15:11];
  assign funct  = instr_w[5:0];
  assign unused_fields = ^{instr_w[25:21], instr_w[10:6]};

  always_comb begin
    dest_valid = 1'b0;
    dest       = 5'd0;
    src        = SRC_ALU;
    if (opcode == OP_SPECIAL) begin
      dest_valid = (funct != FN_JR);
      dest       = rd;
      src        = (funct == FN_JALR) ? SRC_LINK : SRC_ALU;
    end else if (opcode == OP_JAL) begin
      dest_valid = 1'b1;
      dest       = REG_RA;
      src        = SRC_LINK;
    end else if (is_load(opcode)) begin
      dest_valid = 1'b1;
      dest       = rt;
      src        = SRC_LOAD;
    end else if (is_imm_alu(opcode)) begin
      dest_valid = 1'b1;
      dest       = rt;
    end
  end

  load_extend u_load_extend (
    .op       (opcode),
    .mem_data (mem_data_w),
    .off      (alu_result_w[1:0]),
    .data     (load_data)
  );

  always_comb begin
    case (src)
      SRC_LINK: write_data = pc_w + 32'd8;
      SRC_LOAD: write_data = load_data;
      default:  write_data = alu_result_w;
    endcase
  end

  // wb_en qualifies wb_addr/wb_data: when low both are forced to zero so
  // hazard logic downstream can compare addresses without extra gating.
  assign wb_en   = !reset && we_w && dest_valid && (dest != 5'd0);
  assign wb_addr = wb_en ? dest : 5'd0;
  assign wb_data = wb_en ? write_data : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign rs_data_d = (rs_addr_d == 5'd0) ? 32'd0 :
                     (wb_en && rs_addr_d == wb_addr) ? wb_data : regs[rs_addr_d];
  assign rt_data_d = (rt_addr_d == 5'd0) ? 32'd0 :
                     (wb_en && rt_addr_d == wb_addr) ? wb_data : regs[rt_addr_d];

endmodule

// File: tb/tb_writeback_grf.sv
// Directed scoreboard bench for writeback_grf: the driver queues expected
// outputs per vector, a negedge monitor pops and compares.
module tb_writeback_grf;

  localparam int W = 1 + 5 + 32 + 32 + 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_w = '0;
  logic [31:0] instr_w = '0;
  logic [31:0] mem_data_w = '0;
  logic [31:0] alu_result_w = '0;
  logic        we_w = 1'b0;
  logic [4:0]  rs_addr_d = '0;
  logic [4:0]  rt_addr_d = '0;
  logic [31:0] rs_data_d;
  logic [31:0] rt_data_d;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  writeback_grf dut (
    .clk          (clk),
    .reset        (reset),
    .pc_w         (pc_w),
    .instr_w      (instr_w),
    .mem_data_w   (mem_data_w),
    .alu_result_w (alu_result_w),
    .we_w         (we_w),
    .rs_addr_d    (rs_addr_d),
    .rt_addr_d    (rt_addr_d),
    .rs_data_d    (rs_data_d),
    .rt_data_d    (rt_data_d),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  // driver: apply one vector just after a rising edge and queue its expectation
  task automatic issue(input string nm, input logic rst, input logic [31:0] pc,
                       input logic [31:0] instr, input logic [31:0] mem,
                       input logic [31:0] alu, input logic we,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic e_en, input logic [4:0] e_addr, input logic [31:0] e_data,
                       input logic [31:0] e_rs, input logic [31:0] e_rt);
    @(posedge clk);
    #1;
    reset = rst; pc_w = pc; instr_w = instr; mem_data_w = mem;
    alu_result_w = alu; we_w = we; rs_addr_d = rs; rt_addr_d = rt;
    exp_q.push_back({e_en, e_addr, e_data, e_rs, e_rt});
    name_q.push_back(nm);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      string        nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {wb_en, wb_addr, wb_data, rs_data_d, rt_data_d};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s: got en=%0b addr=%0d data=%h rs=%h rt=%h, want en=%0b addr=%0d data=%h rs=%h rt=%h",
                 nm, act_v[101], act_v[100:96], act_v[95:64], act_v[63:32], act_v[31:0],
                 exp_v[101], exp_v[100:96], exp_v[95:64], exp_v[63:32], exp_v[31:0]);
      end
    end
  end

  // commit trace
  always @(posedge clk) begin
    if (wb_en === 1'b1) $display("@%h: $%0d <= %h", pc_w, wb_addr, wb_data);
  end

  localparam logic [31:0] MEM = 32'h80FF7F01;

  initial begin
    int wait_cyc;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    issue("reset_blocks_write", 1, 32'h3000, i_type(6'h0d, 0, 5, 16'h1234), 0, 32'h1234, 1, 5, 5,
          0, 0, 0, 0, 0);
    issue("ori_r5", 0, 32'h3004, i_type(6'h0d, 0, 5, 16'h1234), 0, 32'h1234, 1, 5, 0,
          1, 5, 32'h1234, 32'h1234, 0);
    issue("we0_addiu", 0, 32'h3008, i_type(6'h09, 0, 6, 16'h55), 0, 32'h55, 0, 5, 6,
          0, 0, 0, 32'h1234, 0);
    issue("lb_off2", 0, 32'h300c, i_type(6'h20, 0, 3, 16'h2), MEM, 32'h2, 1, 3, 5,
          1, 3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234);
    issue("lb_off1", 0, 32'h3010, i_type(6'h20, 0, 3, 16'h1), MEM, 32'h1, 1, 3, 3,
          1, 3, 32'h7F, 32'h7F, 32'h7F);
    issue("lhu_off2", 0, 32'h3014, i_type(6'h25, 0, 4, 16'h2), MEM, 32'h2, 1, 3, 4,
          1, 4, 32'h80FF, 32'h7F, 32'h80FF);
    issue("lh_off3", 0, 32'h3018, i_type(6'h21, 0, 4, 16'h3), MEM, 32'h3, 1, 4, 0,
          1, 4, 32'hFFFF80FF, 32'hFFFF80FF, 0);
    issue("lbu_off3", 0, 32'h301c, i_type(6'h24, 0, 7, 16'h3), MEM, 32'h3, 1, 7, 4,
          1, 7, 32'h80, 32'h80, 32'hFFFF80FF);
    issue("lw", 0, 32'h3020, i_type(6'h23, 0, 10, 16'h100), MEM, 32'h100, 1, 10, 10,
          1, 10, MEM, MEM, MEM);
    issue("jal", 0, 32'h3010, {6'h03, 26'h0C04}, 0, 32'hAAAA, 1, 31, 31,
          1, 31, 32'h3018, 32'h3018, 32'h3018);
    issue("jr", 0, 32'h3018, r_type(31, 0, 0, 6'h08), 0, 32'h1111, 1, 31, 7,
          0, 0, 0, 32'h3018, 32'h80);
    issue("jalr", 0, 32'h4000, r_type(31, 0, 2, 6'h09), 0, 32'h2222, 1, 2, 0,
          1, 2, 32'h4008, 32'h4008, 0);
    issue("bypass_both", 0, 32'h4004, r_type(1, 2, 8, 6'h21), 0, 32'hDEADBEEF, 1, 8, 8,
          1, 8, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    issue("addi_r0", 0, 32'h4008, i_type(6'h08, 0, 0, 16'h77), 0, 32'h77, 1, 0, 8,
          0, 0, 0, 0, 32'hDEADBEEF);
    issue("rtype_r0", 0, 32'h400c, r_type(1, 2, 0, 6'h21), 0, 32'h99, 1, 0, 0,
          0, 0, 0, 0, 0);
    issue("sw_nowrite", 0, 32'h4010, i_type(6'h2b, 0, 8, 16'h5), 0, 32'h5, 1, 8, 2,
          0, 0, 0, 32'hDEADBEEF, 32'h4008);
    issue("lui_r9", 0, 32'h4014, i_type(6'h0f, 0, 9, 16'hABCD), 0, 32'hABCD0000, 1, 9, 3,
          1, 9, 32'hABCD0000, 32'hABCD0000, 32'h7F);
    issue("reset_mid", 1, 32'h4018, i_type(6'h09, 0, 9, 16'h1), 0, 32'h1, 1, 9, 5,
          0, 0, 0, 32'hABCD0000, 32'h1234);
    issue("after_reset", 0, 32'h401c, i_type(6'h09, 0, 9, 16'h42), 0, 32'h42, 1, 5, 9,
          1, 9, 32'h42, 0, 32'h42);
    issue("readback", 0, 32'h4020, 32'h0, 0, 0, 0, 9, 3,
          0, 0, 0, 32'h42, 0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
